// File: rtl/rst_req_ctrl.sv
// rtl/rst_req_ctrl.sv - reset request controller: button debounce, pulse/holdoff FSM, cause and count
module rst_req_ctrl #(
  parameter int PULSE_CYCLES    = 16,
  parameter int HOLDOFF_CYCLES  = 32,
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       test_mode_i,
  input  logic       sw_req_i,
  input  logic       wdog_req_i,
  input  logic       ext_btn_ni,
  input  logic       cause_clr_i,
  output logic       rst_req_no,
  output logic       busy_o,
  output logic [2:0] cause_o,
  output logic [7:0] req_cnt_o
);

  localparam int MAX_CYC = (PULSE_CYCLES > HOLDOFF_CYCLES) ? PULSE_CYCLES : HOLDOFF_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam int DBW     = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ASSERT, HOLDOFF} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           start;
  logic           sync1_q, sync2_q;
  logic           db_level_q;
  logic [DBW-1:0] db_cnt_q;
  logic           rst_req_q;
  logic           ext_req;
  logic           any_req;

  assign ext_req = ~db_level_q;
  assign any_req = sw_req_i | wdog_req_i | ext_req;

  // Button path: the debounced level flips only after the synchronized
  // value has disagreed with it for DEBOUNCE_CYCLES cycles in a row.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      db_level_q <= 1'b1;
      db_cnt_q   <= '0;
    end else begin
      sync1_q <= ext_btn_ni;
      sync2_q <= sync1_q;
      if (sync2_q != db_level_q) begin
        if (db_cnt_q == DBW'(DEBOUNCE_CYCLES - 1)) begin
          db_level_q <= sync2_q;
          db_cnt_q   <= '0;
        end else begin
          db_cnt_q <= db_cnt_q + DBW'(1);
        end
      end else begin
        db_cnt_q <= '0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start   = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = ASSERT;
          cnt_d   = '0;
          start   = 1'b1;
        end
      end
      ASSERT: begin
        if (cnt_q == CW'(PULSE_CYCLES - 1)) begin
          state_d = HOLDOFF;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HOLDOFF: begin
        if (cnt_q == CW'(HOLDOFF_CYCLES - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output request is registered from the next state so it goes low the
  // cycle after the triggering request.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rst_req_q <= 1'b1;
      cause_o   <= 3'b000;
      req_cnt_o <= 8'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rst_req_q <= (state_d != ASSERT);
      if (start) begin
        cause_o <= {ext_req, wdog_req_i, sw_req_i};
        if (req_cnt_o != 8'hFF) req_cnt_o <= req_cnt_o + 8'd1;
      end else if (state_q == IDLE && cause_clr_i) begin
        cause_o <= 3'b000;
      end
    end
  end

  assign rst_req_no = rst_req_q | test_mode_i;
  assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_rst_req_ctrl.sv
// tb/tb_rst_req_ctrl.sv - scoreboard bench for rst_req_ctrl with a timeline reference model
module tb_rst_req_ctrl;
  localparam int P = 16;
  localparam int H = 32;
  localparam int D = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0, test_mode = 1'b0, sw = 1'b0, wdog = 1'b0, btn_n = 1'b1, clr = 1'b0;
  logic rst_req_n, busy;
  logic [2:0] cause;
  logic [7:0] req_cnt;

  always #5 clk = ~clk;

  rst_req_ctrl #(.PULSE_CYCLES(P), .HOLDOFF_CYCLES(H), .DEBOUNCE_CYCLES(D)) dut (
    .clk_i(clk), .rst_ni(rst_n), .test_mode_i(test_mode), .sw_req_i(sw),
    .wdog_req_i(wdog), .ext_btn_ni(btn_n), .cause_clr_i(clr),
    .rst_req_no(rst_req_n), .busy_o(busy), .cause_o(cause), .req_cnt_o(req_cnt)
  );

  typedef struct {
    logic       rst_q;
    logic       busy;
    logic [2:0] cause;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int waited = 0;

  logic   m_s1, m_s2, m_db;
  int     m_run, m_left, m_cnt;
  logic [2:0] m_cause;

  always @(posedge clk) begin
    exp_t e;
    logic ext_now;
    if (!rst_n) begin
      m_s1 = 1'b1; m_s2 = 1'b1; m_db = 1'b1; m_run = 0;
      m_left = 0; m_cnt = 0; m_cause = 3'b000;
    end else begin
      ext_now = ~m_db;
      if (m_left == 0 && (sw || wdog || ext_now)) begin
        m_left  = P + H;
        m_cause = {ext_now, wdog, sw};
        m_cnt   = (m_cnt < 255) ? m_cnt + 1 : 255;
      end else if (m_left == 0 && clr) begin
        m_cause = 3'b000;
      end else if (m_left != 0) begin
        m_left = m_left - 1;
      end
      if (m_s2 != m_db) begin
        m_run = m_run + 1;
        if (m_run == D) begin
          m_db  = m_s2;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
      m_s2 = m_s1;
      m_s1 = btn_n;
    end
    e.rst_q = !(m_left > H);
    e.busy  = (m_left != 0);
    e.cause = m_cause;
    e.cnt   = m_cnt[7:0];
    sb.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (rst_req_n !== (e.rst_q | test_mode) || busy !== e.busy ||
          cause !== e.cause || req_cnt !== e.cnt) begin
        errors++;
        $display("FAIL outputs t=%0t: got rst_req_no=%b busy=%b cause=%b cnt=%0d, want rst_req_no=%b busy=%b cause=%b cnt=%0d",
                 $time, rst_req_n, busy, cause, req_cnt, e.rst_q | test_mode, e.busy, e.cause, e.cnt);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sw_pulse();
    sw = 1'b1;
    step(1);
    sw = 1'b0;
  endtask

  initial begin
    step(3);
    checks++;
    if (rst_req_n !== 1'b1 || busy !== 1'b0 || cause !== 3'b000 || req_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset state t=%0t: rst_req_no=%b busy=%b cause=%b cnt=%0d",
               $time, rst_req_n, busy, cause, req_cnt);
    end
    rst_n = 1'b1;
    step(9);
    sw_pulse();
    waited = 0;
    while (busy && waited < P + H + 5) begin
      step(1);
      waited++;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL wait expired t=%0t: busy_o still high after %0d cycles", $time, waited);
    end
    if (waited < 60) step(60 - waited);
    clr = 1'b1; step(1); clr = 1'b0; step(3);
    sw = 1'b1; wdog = 1'b1; step(1); sw = 1'b0; wdog = 1'b0;
    step(30);
    sw_pulse();
    step(40);
    test_mode = 1'b1;
    sw_pulse();
    step(55);
    test_mode = 1'b0;
    for (int i = 0; i < 10; i++) begin
      btn_n = ~btn_n;
      step(3);
    end
    btn_n = 1'b0;
    step(20);
    btn_n = 1'b1;
    step(70);
    sw_pulse();
    step(5);
    rst_n = 1'b0; step(1); rst_n = 1'b1;
    step(5);
    for (int i = 0; i < 3000; i++) begin
      sw        = ($urandom_range(0, 19) == 0);
      clr       = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 99) == 0) wdog = ~wdog;
      if ($urandom_range(0, 6) == 0) btn_n = ~btn_n;
      if ($urandom_range(0, 199) == 0) test_mode = ~test_mode;
      rst_n     = ($urandom_range(0, 999) != 0);
      step(1);
    end
    sw = 1'b0; clr = 1'b0; wdog = 1'b0; btn_n = 1'b1; test_mode = 1'b0; rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    wdog = 1'b1;
    step(256 * (P + H + 1) + 20);
    wdog = 1'b0;
    step(P + H + 5);
    @(negedge clk);
    #1;
    if (errors != 0 || checks == 0)
      $display("FAIL: %0d checks, %0d errors", checks, errors);
    else
      $display("PASS: %0d checks", checks);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
